// File: rtl/cycle_pkg.sv
// Shared types and constants for the cycle sequencer: FSM state encoding,
// position/lap/prescaler widths and the position/lap update helpers.
package cycle_pkg;

  localparam int POS_W = 4;
  localparam int LAP_W = 4;
  localparam int DIV_W = 16;

  localparam logic [LAP_W-1:0] LAP_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Next ring position in the given direction; MSB flags a wrap in either direction.
  function automatic logic [POS_W:0] advance_pos(
    input logic [POS_W-1:0] cur,
    input logic             ccw,
    input logic [POS_W-1:0] last_pos
  );
    logic [POS_W:0] res;
    if (ccw) begin
      if (cur == {POS_W{1'b0}}) begin
        res = {1'b1, last_pos};
      end else begin
        res = {1'b0, cur - POS_W'(1)};
      end
    end else begin
      if (cur >= last_pos) begin
        res = {1'b1, {POS_W{1'b0}}};
      end else begin
        res = {1'b0, cur + POS_W'(1)};
      end
    end
    return res;
  endfunction

  // Lap count increment that sticks at LAP_MAX.
  function automatic logic [LAP_W-1:0] sat_inc_lap(input logic [LAP_W-1:0] cur);
    logic [LAP_W-1:0] res;
    if (cur >= LAP_MAX) begin
      res = LAP_MAX;
    end else begin
      res = cur + LAP_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler for the cycle sequencer. Counts 0..divisor-1 while run is high and
// flags the wrap cycle on tick; the caller registers tick into its step pulse.
// A divisor change is honoured at once: a count already at or beyond the new
// terminal value wraps on the current cycle.
module tick_divider
  import cycle_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_limit;
  logic             w_at_end;

  // Terminal count for the current divisor and the wrap condition.
  always_comb begin
    w_limit  = {DIV_W{1'b0}};
    w_at_end = 1'b0;
    if (divisor == {DIV_W{1'b0}}) begin
      w_limit = {DIV_W{1'b0}};
    end else begin
      w_limit = divisor - DIV_W'(1);
    end
    w_at_end = (r_count >= w_limit);
    tick     = run & w_at_end;
  end

  // Prescale counter: clears on request, counts/wraps in run, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {DIV_W{1'b0}};
    end else if (clear) begin
      r_count <= {DIV_W{1'b0}};
    end else if (run) begin
      if (w_at_end) begin
        r_count <= {DIV_W{1'b0}};
      end else begin
        r_count <= r_count + DIV_W'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Run/pause/idle sequencer for a rotating display ring. Drives the datapath
// enable, direction and step pulse, and tracks ring position and lap count.
// Every output comes straight from a register.
module cycle_sequencer
  import cycle_pkg::*;
#(
  parameter int CLK_DIV_BASE  = 4,
  parameter int STEPS_PER_LAP = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_toggle,
  input  logic [1:0]       speed,
  output logic             en,
  output logic             sel,
  output logic             step,
  output logic [POS_W-1:0] pos,
  output logic [LAP_W-1:0] lap,
  output logic [1:0]       state
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEPS_PER_LAP - 1);

  state_t           r_state;
  logic             r_en;
  logic             r_sel;
  logic             r_step;
  logic [POS_W-1:0] r_pos;
  logic [LAP_W-1:0] r_lap;

  logic [DIV_W-1:0] w_divisor;
  logic             w_run;
  logic             w_clear;
  logic             w_tick;
  logic [POS_W:0]   w_adv;

  // Divisor selection, prescaler control and the next ring position.
  always_comb begin
    w_divisor = DIV_W'(CLK_DIV_BASE) << speed;
    w_run     = (r_state == ST_RUN);
    // Leaving PAUSE for IDLE is the only way into IDLE after reset.
    w_clear   = (r_state == ST_PAUSE) && stop;
    w_adv     = advance_pos(r_pos, r_sel, LAST_POS);
  end

  tick_divider u_tick_divider (
    .clk     (clk),
    .rst     (rst),
    .run     (w_run),
    .clear   (w_clear),
    .divisor (w_divisor),
    .tick    (w_tick)
  );

  // FSM with registered enable, direction, step pulse and position/lap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_sel   <= 1'b0;
      r_step  <= 1'b0;
      r_pos   <= {POS_W{1'b0}};
      r_lap   <= {LAP_W{1'b0}};
    end else begin
      // Tick is only ever high in RUN, so PAUSE/IDLE never pulse step.
      r_step <= w_tick;

      // Direction flips in any state; a coincident step used the old value above.
      if (dir_toggle) begin
        r_sel <= ~r_sel;
      end else begin
        r_sel <= r_sel;
      end

      // Position advances on the same edge the step pulse is launched.
      if (w_tick) begin
        r_pos <= w_adv[POS_W-1:0];
        if (w_adv[POS_W]) begin
          r_lap <= sat_inc_lap(r_lap);
        end else begin
          r_lap <= r_lap;
        end
      end else begin
        r_pos <= r_pos;
        r_lap <= r_lap;
      end

      case (r_state)
        ST_IDLE: begin
          // Stop wins over a simultaneous start.
          if (start && !stop) begin
            r_state <= ST_RUN;
            r_en    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_PAUSE;
            r_en    <= 1'b0;
          end else begin
            r_state <= ST_RUN;
            r_en    <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_pos   <= {POS_W{1'b0}};
            r_lap   <= {LAP_W{1'b0}};
          end else if (start) begin
            r_state <= ST_RUN;
            r_en    <= 1'b1;
          end else begin
            r_state <= ST_PAUSE;
            r_en    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_pos   <= {POS_W{1'b0}};
          r_lap   <= {LAP_W{1'b0}};
        end
      endcase
    end
  end

  assign en    = r_en;
  assign sel   = r_sel;
  assign step  = r_step;
  assign pos   = r_pos;
  assign lap   = r_lap;
  assign state = r_state;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer (CLK_DIV_BASE=4, STEPS_PER_LAP=12):
// a vector table for the basic FSM flow plus hand-written multi-cycle sequences.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir_toggle;
  logic [1:0] speed;
  logic       en;
  logic       sel;
  logic       step;
  logic [3:0] pos;
  logic [3:0] lap;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  cycle_sequencer #(
    .CLK_DIV_BASE  (4),
    .STEPS_PER_LAP (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir_toggle (dir_toggle),
    .speed      (speed),
    .en         (en),
    .sel        (sel),
    .step       (step),
    .pos        (pos),
    .lap        (lap),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       i_start;
    logic       i_stop;
    logic       i_dir;
    logic [1:0] i_speed;
    logic [1:0] e_state;
    logic       e_en;
    logic       e_sel;
    logic       e_step;
    logic [3:0] e_pos;
    logic [3:0] e_lap;
  } vec_t;

  vec_t tbl [20];

  // One clock: inputs applied at the falling edge, outputs settle 1 after the rising edge.
  task automatic drive(input logic s, input logic p, input logic d, input logic [1:0] sp);
    @(negedge clk);
    start      = s;
    stop       = p;
    dir_toggle = d;
    speed      = sp;
    @(posedge clk);
    #1;
    start      = 1'b0;
    stop       = 1'b0;
    dir_toggle = 1'b0;
  endtask

  task automatic check_all(input string nm, input logic [1:0] es, input logic ee,
                           input logic esl, input logic est, input logic [3:0] ep,
                           input logic [3:0] el);
    n_cmp++;
    if ({state, en, sel, step, pos, lap} !== {es, ee, esl, est, ep, el}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d en=%0b sel=%0b step=%0b pos=%0d lap=%0d, want state=%0d en=%0b sel=%0b step=%0b pos=%0d lap=%0d",
               nm, state, en, sel, step, pos, lap, es, ee, esl, est, ep, el);
    end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    dir_toggle = 1'b0;
    speed      = 2'd0;

    // Basic flow: run, step cadence, pause/resume, stop-wins, clear, direction toggle.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

    // Reset held low, then released; block must stay idle without start.
    repeat (2) @(negedge clk);
    #1;
    check_all("reset_low", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    check_all("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].i_start, tbl[i].i_stop, tbl[i].i_dir, tbl[i].i_speed);
      check_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_en, tbl[i].e_sel,
                tbl[i].e_step, tbl[i].e_pos, tbl[i].e_lap);
    end

    // One full lap at speed 0: step every 4 cycles, lap=1 after 48 cycles.
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    check_all("lap_start", 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 48; k++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      check_all($sformatf("lap_k%0d", k), 2'd1, 1'b1, 1'b0, ((k % 4) == 0),
                4'((k / 4) % 12), 4'((k >= 48) ? 1 : 0));
    end

    // Direction flip at pos 0: next step wraps down to 11 and counts a lap.
    drive(1'b0, 1'b0, 1'b1, 2'd0);
    check_all("dir_flip", 2'd1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    check_all("dir_wait", 2'd1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    check_all("dir_wrap", 2'd1, 1'b1, 1'b1, 1'b1, 4'd11, 4'd2);

    // Speed 2: 16-cycle period.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd2);
      check_all($sformatf("spd2_i%0d", i), 2'd1, 1'b1, 1'b1, (i == 16),
                4'((i == 16) ? 10 : 11), 4'd2);
    end
    // Prescaler up to 10, then drop to speed 0: immediate step, then every 4.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd2);
      check_all($sformatf("spd2_hold%0d", i), 2'd1, 1'b1, 1'b1, 1'b0, 4'd10, 4'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    check_all("spd_drop_step", 2'd1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      check_all($sformatf("spd0_i%0d", i), 2'd1, 1'b1, 1'b1, (i == 4),
                4'((i == 4) ? 8 : 9), 4'd2);
    end

    // 200 laps: 2400 steps bring pos back to 8 with lap saturated.
    for (int i = 0; i < 9600; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0);
    end
    check_all("lap_saturate", 2'd1, 1'b1, 1'b1, 1'b1, 4'd8, 4'd15);

    // Bring prescaler to its terminal count, then reset just before the step edge.
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    check_all("pre_reset", 2'd1, 1'b1, 1'b1, 1'b0, 4'd8, 4'd15);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    check_all("reset_no_step", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      check_all($sformatf("post_reset_idle%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    check_all("restart", 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0);
      check_all($sformatf("restart_i%0d", i), 2'd1, 1'b1, 1'b0, (i == 4),
                4'((i == 4) ? 1 : 0), 4'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter CLK_DIV_BASE, default 4: base prescale count in clk cycles per step.
REQ-002 Parameter STEPS_PER_LAP, default 12: number of segment positions in one revolution of the display ring.
REQ-003 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low.
REQ-005 start  input  1  single-cycle pulse, already debounced: run or resume.
REQ-006 stop  input  1  single-cycle pulse, already debounced: pause, or clear when already paused.
REQ-007 dir_toggle  input  1  single-cycle pulse: invert rotation direction.
REQ-008 speed  input  2  prescale select; divisor = CLK_DIV_BASE << speed.
REQ-009 en  output  1  high while in RUN; drives the cycle datapath enable.
REQ-010 sel  output  1  rotation direction to the datapath: 0 = clockwise, 1 = counter-clockwise.
REQ-011 step  output  1  one-clk pulse that advances the datapath one position.
REQ-012 pos  output  4  current ring position, 0..STEPS_PER_LAP-1.
REQ-013 lap  output  4  count of completed revolutions, saturating.
REQ-014 state  output  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-016 IDLE SHALL go to RUN on start; RUN SHALL go to PAUSE on stop; PAUSE SHALL go to RUN on start; PAUSE SHALL go to IDLE on stop.
REQ-017 When start and stop are both high in the same cycle, stop SHALL win.
REQ-018 Entering IDLE SHALL clear pos, lap and the prescaler, and SHALL leave sel unchanged.
REQ-019 In RUN the prescaler SHALL count 0..divisor-1; step SHALL assert for one cycle in the cycle after the prescaler reaches divisor-1, and the prescaler SHALL then wrap to 0.
REQ-020 In PAUSE the prescaler, pos and lap SHALL hold, and step SHALL stay low.
REQ-021 The first step after IDLE->RUN SHALL occur exactly divisor cycles after the cycle in which start is sampled.
REQ-022 On each step, pos SHALL increment when sel=0 and decrement when sel=1, wrapping STEPS_PER_LAP-1->0 and 0->STEPS_PER_LAP-1 respectively.
REQ-023 Each pos wrap (in either direction) SHALL increment lap, saturating at 15.
REQ-024 dir_toggle SHALL invert sel in any state, effective the next cycle; a step coincident with dir_toggle SHALL use the old sel.
REQ-025 A speed change SHALL be taken up immediately; if the prescaler is already at or above the new divisor-1, the prescaler SHALL wrap and step SHALL fire on the next cycle.
REQ-026 en SHALL equal (state==RUN), registered with state.
REQ-027 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-028 While rst is low: state=IDLE, en=0, sel=0, step=0, pos=0, lap=0, prescaler=0, asynchronously.
REQ-029 Assertion of rst mid-step or mid-RUN SHALL abort immediately with no further step pulse.
REQ-030 After deassertion the block SHALL remain in IDLE until start is sampled.

Structure
REQ-031 Package cycle_pkg SHALL hold the state enum, the pos/lap width constants and the lap saturation value.
REQ-032 The prescaler SHALL be a separate sub-module tick_divider, with inputs clk, rst, run, clear and divisor, and output tick.
REQ-033 The FSM and the position/lap counters SHALL reside in cycle_sequencer.

Verification (CLK_DIV_BASE=4, STEPS_PER_LAP=12)
REQ-034 Reset, then start with speed=0 -> en=1 next cycle; step every 4 cycles; pos 0,1,2...11,0 with lap=1 after 48 cycles.
REQ-035 speed=2 in RUN -> step period 16 cycles; switch to speed=0 with prescaler=10 -> step on next cycle, then every 4 cycles.
REQ-036 dir_toggle at pos=0 -> sel=1, next step gives pos=11 and lap increments.
REQ-037 stop in RUN -> PAUSE, no step, pos held; start -> resume with pos continuing; stop twice -> IDLE, pos=0, lap=0.
REQ-038 start and stop in the same cycle while in IDLE -> remains in IDLE; the same event in RUN -> PAUSE.
REQ-039 Run 200 laps -> lap saturates at 15; rst low mid-RUN -> all outputs reset asynchronously, with no step pulse in that cycle.
